// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem read, a registered output slot for decode,
// a one-entry skid buffer, and flush/redirect handling for late responses.
//
// state | meaning
// ISSUE | may launch a request at pc when the output slot is free
// WAIT  | request outstanding, waiting for imemValid
// HOLD  | response parked in bufInst/bufPc until decode accepts
// DROP  | outstanding response belongs to a flushed path, discard it
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemRdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic [31:0] instOut,
  output logic [6:0]  opcodeOut,
  output logic [31:0] pcOut,
  output logic        instValid
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_pc_out;
  logic        r_valid;
  logic [31:0] r_buf_inst;
  logic [31:0] r_buf_pc;

  logic        w_free;
  logic        w_consume;
  logic [31:0] w_pc_next;
  logic        w_in_flight;

  assign w_free      = !r_valid || !stall;
  assign w_consume   = r_valid && !stall;
  assign w_pc_next   = r_pc + 32'd4;
  assign w_in_flight = (r_state == WAIT) || (r_state == DROP);

  assign imemReq   = rst_n && (r_state == ISSUE) && w_free && !redirect;
  assign imemAddr  = r_pc;
  assign instOut   = r_inst;
  assign opcodeOut = r_inst[6:0];
  assign pcOut     = r_pc_out;
  assign instValid = r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ISSUE;
      r_pc       <= RESET_PC;
      r_inst     <= NOP;
      r_pc_out   <= 32'h0;
      r_valid    <= 1'b0;
      r_buf_inst <= 32'h0;
      r_buf_pc   <= 32'h0;
    end else if (redirect) begin
      r_pc    <= redirectPc & 32'hFFFF_FFFC;
      r_valid <= 1'b0;
      // a response landing together with the redirect closes the outstanding request
      r_state <= (w_in_flight && !imemValid) ? DROP : ISSUE;
    end else begin
      case (r_state)
        ISSUE: begin
          if (w_consume) r_valid <= 1'b0;
          if (w_free) r_state <= WAIT;
        end
        WAIT: begin
          if (imemValid) begin
            r_pc <= w_pc_next;
            if (w_free) begin
              r_inst   <= imemRdata;
              r_pc_out <= r_pc;
              r_valid  <= 1'b1;
              r_state  <= ISSUE;
            end else begin
              r_buf_inst <= imemRdata;
              r_buf_pc   <= r_pc;
              r_state    <= HOLD;
            end
          end else if (w_consume) begin
            r_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            r_inst   <= r_buf_inst;
            r_pc_out <= r_buf_pc;
            r_valid  <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        DROP: begin
          if (w_consume) r_valid <= 1'b0;
          if (imemValid) r_state <= ISSUE;
        end
        default: r_state <= ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table for the corner cases, then randomized
// stall/redirect/latency traffic checked against a program-order reference model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemValid;
  logic [31:0] imemRdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;
  logic [31:0] instOut;
  logic [6:0]  opcodeOut;
  logic [31:0] pcOut;
  logic        instValid;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imemReq(imemReq), .imemAddr(imemAddr),
    .imemValid(imemValid), .imemRdata(imemRdata),
    .stall(stall), .redirect(redirect), .redirectPc(redirectPc),
    .instOut(instOut), .opcodeOut(opcodeOut), .pcOut(pcOut), .instValid(instValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] LD  = 32'h00C0_A283;
  localparam logic [31:0] ST  = 32'h0082_A223;

  typedef struct {
    logic        rst_n, stall, redirect;
    logic [31:0] rpc;
    logic        vld;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst, e_pc;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(logic r, logic s, logic rd, logic [31:0] rpc, logic vl,
                              logic [31:0] rdat, logic er, logic [31:0] ea, logic ev,
                              logic [31:0] ei, logic [31:0] ep);
    vec_t t;
    t.rst_n = r; t.stall = s; t.redirect = rd; t.rpc = rpc; t.vld = vl; t.rdata = rdat;
    t.e_req = er; t.e_addr = ea; t.e_iv = ev; t.e_inst = ei; t.e_pc = ep;
    return t;
  endfunction

  function automatic logic [31:0] memfn(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // random-phase model state
  logic        pending;
  logic [31:0] paddr;
  int          lat;
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  logic        prev_hold;
  logic [31:0] prev_inst, prev_pc;
  int          consumed;

  initial begin
    //             rst s  rd rpc            v  rdata  | req addr           iv inst pcOut
    vecs[0]  = mk(1, 0, 0, 32'h0,         0, 32'h0, 1, 32'h0,         0, NOP, 32'h0);
    vecs[1]  = mk(1, 0, 0, 32'h0,         1, LD,    0, 32'h0,         0, NOP, 32'h0);
    vecs[2]  = mk(1, 0, 0, 32'h0,         0, 32'h0, 1, 32'h4,         1, LD,  32'h0);
    vecs[3]  = mk(1, 0, 0, 32'h0,         1, LD,    0, 32'h4,         0, LD,  32'h0);
    vecs[4]  = mk(1, 0, 0, 32'h0,         0, 32'h0, 1, 32'h8,         1, LD,  32'h4);
    vecs[5]  = mk(1, 1, 0, 32'h0,         0, 32'h0, 0, 32'h8,         0, LD,  32'h4);
    vecs[6]  = mk(1, 1, 0, 32'h0,         1, ST,    0, 32'h8,         0, LD,  32'h4);
    vecs[7]  = mk(1, 1, 0, 32'h0,         0, 32'h0, 0, 32'hC,         1, ST,  32'h8);
    vecs[8]  = mk(1, 1, 0, 32'h0,         0, 32'h0, 0, 32'hC,         1, ST,  32'h8);
    vecs[9]  = mk(1, 0, 0, 32'h0,         0, 32'h0, 1, 32'hC,         1, ST,  32'h8);
    vecs[10] = mk(1, 0, 1, 32'h102,       0, 32'h0, 0, 32'hC,         0, ST,  32'h8);
    vecs[11] = mk(1, 0, 0, 32'h0,         0, 32'h0, 0, 32'h100,       0, ST,  32'h8);
    vecs[12] = mk(1, 0, 0, 32'h0,         1, LD,    0, 32'h100,       0, ST,  32'h8);
    vecs[13] = mk(1, 0, 0, 32'h0,         0, 32'h0, 1, 32'h100,       0, ST,  32'h8);
    vecs[14] = mk(1, 0, 0, 32'h0,         1, ST,    0, 32'h100,       0, ST,  32'h8);
    vecs[15] = mk(1, 0, 0, 32'h0,         0, 32'h0, 1, 32'h104,       1, ST,  32'h100);
    vecs[16] = mk(1, 0, 1, 32'h200,       1, LD,    0, 32'h104,       0, ST,  32'h100);
    vecs[17] = mk(1, 0, 0, 32'h0,         0, 32'h0, 1, 32'h200,       0, ST,  32'h100);
    vecs[18] = mk(1, 0, 1, 32'hFFFF_FFFF, 0, 32'h0, 0, 32'h200,       0, ST,  32'h100);
    vecs[19] = mk(1, 0, 0, 32'h0,         1, LD,    0, 32'hFFFF_FFFC, 0, ST,  32'h100);
    vecs[20] = mk(1, 0, 0, 32'h0,         0, 32'h0, 1, 32'hFFFF_FFFC, 0, ST,  32'h100);
    vecs[21] = mk(1, 0, 0, 32'h0,         1, LD,    0, 32'hFFFF_FFFC, 0, ST,  32'h100);
    vecs[22] = mk(1, 0, 0, 32'h0,         0, 32'h0, 1, 32'h0,         1, LD,  32'hFFFF_FFFC);
    vecs[23] = mk(1, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0,         0, LD,  32'hFFFF_FFFC);
    vecs[24] = mk(0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0,         0, NOP, 32'h0);
    vecs[25] = mk(1, 0, 0, 32'h0,         1, LD,    1, 32'h0,         0, NOP, 32'h0);
    vecs[26] = mk(1, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0,         0, NOP, 32'h0);
    vecs[27] = mk(1, 0, 0, 32'h0,         1, ST,    0, 32'h0,         0, NOP, 32'h0);
    vecs[28] = mk(1, 1, 0, 32'h0,         0, 32'h0, 0, 32'h4,         1, ST,  32'h0);

    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPc = 32'h0;
    imemValid = 1'b0; imemRdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset imemReq",    32'(imemReq),   32'd0);
    chk("reset imemAddr",   imemAddr,       32'h0);
    chk("reset instValid",  32'(instValid), 32'd0);
    chk("reset instOut",    instOut,        NOP);
    chk("reset opcodeOut",  32'(opcodeOut), 32'h13);
    chk("reset pcOut",      pcOut,          32'h0);

    for (int i = 0; i < 29; i++) begin
      logic [31:0] ei;
      @(posedge clk); #1;
      rst_n      = vecs[i].rst_n;
      stall      = vecs[i].stall;
      redirect   = vecs[i].redirect;
      redirectPc = vecs[i].rpc;
      imemValid  = vecs[i].vld;
      imemRdata  = vecs[i].rdata;
      @(negedge clk);
      ei = vecs[i].e_inst;
      chk($sformatf("row%0d imemReq", i),   32'(imemReq),   32'(vecs[i].e_req));
      chk($sformatf("row%0d imemAddr", i),  imemAddr,       vecs[i].e_addr);
      chk($sformatf("row%0d instValid", i), 32'(instValid), 32'(vecs[i].e_iv));
      chk($sformatf("row%0d instOut", i),   instOut,        ei);
      chk($sformatf("row%0d opcodeOut", i), 32'(opcodeOut), 32'(ei[6:0]));
      chk($sformatf("row%0d pcOut", i),     pcOut,          vecs[i].e_pc);
    end

    // randomized phase, fresh reset
    @(posedge clk); #1;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; imemValid = 1'b0;
    pending = 1'b0; lat = 0; paddr = 32'h0; exp_pc = 32'h0; prev_hold = 1'b0;
    prev_inst = 32'h0; prev_pc = 32'h0; consumed = 0;
    for (int it = 0; it < 4000; it++) begin
      @(posedge clk); #1;
      rst_n      = 1'b1;
      stall      = ($urandom_range(0, 9) < 3);
      redirect   = ($urandom_range(0, 19) == 0);
      redirectPc = $urandom;
      imemValid  = 1'b0;
      imemRdata  = $urandom;
      if (pending) begin
        if (lat == 0) begin
          imemValid = 1'b1;
          imemRdata = memfn(paddr);
          pending   = 1'b0;
        end else begin
          lat--;
        end
      end
      @(negedge clk);
      if (prev_hold) begin
        chk("held instValid", 32'(instValid), 32'd1);
        chk("held instOut",   instOut,        prev_inst);
        chk("held pcOut",     pcOut,          prev_pc);
      end
      if (imemReq) begin
        chk("illegal imemReq",
            32'((instValid && stall) || redirect || pending || imemValid), 32'd0);
        pending = 1'b1;
        paddr   = imemAddr;
        lat     = $urandom_range(0, 2);
      end
      if (redirect) begin
        exp_pc = redirectPc & 32'hFFFF_FFFC;
      end else if (instValid && !stall) begin
        exp_inst = memfn(exp_pc);
        chk("stream pcOut",     pcOut,          exp_pc);
        chk("stream instOut",   instOut,        exp_inst);
        chk("stream opcodeOut", 32'(opcodeOut), 32'(exp_inst[6:0]));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      prev_hold = instValid && stall && !redirect;
      prev_inst = instOut;
      prev_pc   = pcOut;
    end
    chk("forward progress", 32'(consumed > 200), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset; bits [1:0] SHALL be 0.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous assert, active-low.
REQ-004 The block SHALL have port imemReq, output, 1, a one-cycle instruction-memory read request.
REQ-005 The block SHALL have port imemAddr, output, 32, the read address, valid while imemReq=1 and equal to the internal pc otherwise.
REQ-006 The block SHALL have port imemValid, input, 1, a one-cycle response strobe, one or more cycles after imemReq.
REQ-007 The block SHALL have port imemRdata, input, 32, the response instruction word, sampled only when imemValid=1.
REQ-008 The block SHALL have port stall, input, 1, meaning decode cannot accept the held instruction this cycle.
REQ-009 The block SHALL have port redirect, input, 1, a branch/jump taken signal that flushes and redirects the PC.
REQ-010 The block SHALL have port redirectPc, input, 32, the redirect target.
REQ-011 The block SHALL have port instOut, output, 32, the registered instruction presented to decode and the immediate generator.
REQ-012 The block SHALL have port opcodeOut, output, 7, which SHALL always equal instOut[6:0].
REQ-013 The block SHALL have port pcOut, output, 32, the address that instOut was fetched from.
REQ-014 The block SHALL have port instValid, output, 1, meaning instOut/pcOut hold an unconsumed instruction.

Function
REQ-015 The block SHALL allow one outstanding memory request at a time.
REQ-016 The state machine SHALL have states ISSUE, WAIT, HOLD and DROP, with one-entry skid buffer registers bufInst/bufPc.
REQ-017 In ISSUE, imemReq SHALL be 1 iff (!instValid || !stall) && !redirect; when it is 1, imemAddr=pc and the next state SHALL be WAIT; otherwise the state SHALL remain ISSUE.
REQ-018 In WAIT with imemValid=1 and output free (!instValid || !stall): instOut<=imemRdata, pcOut<=pc, instValid<=1, pc<=pc+4, next state ISSUE.
REQ-019 In WAIT with imemValid=1 and instValid && stall: bufInst<=imemRdata, bufPc<=pc, pc<=pc+4, next state HOLD.
REQ-020 In HOLD with stall=0: the output SHALL load from the buffer with instValid=1 and the next state SHALL be ISSUE; with stall=1 the block SHALL remain in HOLD with outputs unchanged.
REQ-021 In any state, an instruction is consumed on a cycle with instValid=1 && stall=0; when nothing new loads that cycle, instValid SHALL go to 0 on the next edge.
REQ-022 While instValid=1 && stall=1, instOut, opcodeOut and pcOut SHALL be held stable.
REQ-023 Redirect SHALL have priority over everything: pc<=redirectPc with bits [1:0] forced to 0, instValid<=0, and the buffer discarded.
REQ-024 On redirect, the next state SHALL be DROP if in WAIT with imemValid=0, otherwise ISSUE (a response arriving in the same cycle is discarded).
REQ-025 In DROP, the block SHALL wait for imemValid, discard the data, leave pc unchanged, and then go to ISSUE; a redirect in DROP SHALL update pc and stay in DROP.
REQ-026 imemValid in ISSUE or HOLD SHALL be ignored.
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-028 Minimum latency SHALL be: request at cycle N, imemValid at N+1, instValid=1 at N+2; peak throughput is one instruction per 2 cycles.

Reset
REQ-029 While rst_n=0: pc=RESET_PC, state=ISSUE, imemReq=0, instOut=32'h0000_0013 (NOP), opcodeOut=7'b0010011, pcOut=0, instValid=0, buffer empty.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; the first edge after rst_n rises SHALL issue a request at RESET_PC.

Verification
REQ-031 Reset release, memory returns 32'h00C0A283 one cycle after each request -> imemAddr 0, 4, 8...; instValid=1 with pcOut=0, opcodeOut=7'b0000011.
REQ-032 stall=1 held 3 cycles while a response 32'h0082A223 arrives -> HOLD entered, instOut unchanged, no imemReq; after stall=0, instOut=32'h0082A223 in order, no loss or duplication.
REQ-033 redirect=1, redirectPc=32'h0000_0102 while in WAIT -> response discarded (DROP), next imemAddr=32'h0000_0100, instValid=0 until the new response.
REQ-034 redirect coincident with imemValid in WAIT -> data not presented, next state ISSUE, next imemAddr=redirect target.
REQ-035 pc=32'hFFFF_FFFC fetch -> next imemAddr=32'h0000_0000.
REQ-036 rst_n pulsed low during WAIT -> outputs at reset values immediately; next request at RESET_PC; a late imemValid in ISSUE is ignored.
